raizing_gfx_rom_arb: RTL and testbench
======================================

Name: raizing_gfx_rom_arb

Overview:
- Parametrised N-channel graphics ROM fetch arbiter for the Raizing video subsystem.
- Merges per-layer tile fetch requests (OBJ, SCR0..SCRn) onto one SDRAM/ROM slot, so layer count no longer costs one ROM port each.
- Keeps a one-entry hit register per channel, so repeated fetches of the same address return without a ROM cycle.
- Sits between the GCU layer fetch logic and the top-level GFX ROM port.

Parameters:
- NUM_CH, 4, number of requesting channels (1..8).
- AW, 22, ROM word address width.
- DW, 32, ROM data width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest).
- MIN_WAIT, 1, cycles ROM_CS must be held before ROM_OK is trusted (1..3).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  reset.
- CH_CS  in  NUM_CH  per-channel request, held high until CH_OK is seen.
- CH_ADDR  in  NUM_CH*AW  per-channel address; channel i uses bits [i*AW +: AW].
- CH_OK  out  NUM_CH  per-channel data valid for the current CH_ADDR.
- CH_DOUT  out  NUM_CH*DW  per-channel returned data.
- ROM_CS  out  1  ROM request.
- ROM_ADDR  out  AW  ROM address.
- ROM_OK  in  1  ROM data valid.
- ROM_DOUT  in  DW  ROM data.
- BUSY  out  1  arbiter has a ROM transaction in flight.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All outputs, state, tags, valid bits and the round-robin pointer clear to 0.
- Per-channel hit register: tag[AW], data[DW], vld.
- CH_OK[i] = CH_CS[i] & vld[i] & (tag[i] == CH_ADDR[i]). This is combinational, so CH_OK drops in the same cycle the address changes. CH_DOUT[i] = data[i], registered.
- Pending[i] = CH_CS[i] & ~CH_OK[i].
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any pending: select a winner. RR mode picks the first pending index at or after ptr, wrapping. Fixed mode picks the lowest pending index.
  - Latch gidx and gaddr = CH_ADDR[gidx]; set ROM_CS = 1, ROM_ADDR = gaddr; go to ISSUE.
  - Same cycle, in RR mode, ptr = gidx+1 mod NUM_CH.
- ISSUE: count MIN_WAIT cycles with ROM_CS held, ignoring ROM_OK, then go to WAIT.
- WAIT:
  - On ROM_OK: tag[gidx] = gaddr, data[gidx] = ROM_DOUT, vld[gidx] = 1; ROM_CS = 0; go to DONE.
  - No timeout; WAIT holds indefinitely.
- DONE: one idle cycle so the ROM controller sees CS low, then go to IDLE.
- Grant latency:
  - Uncontended miss: CH_OK rises MIN_WAIT+2 cycles after CH_CS, plus ROM latency.
  - Hit: CH_OK is high in the same cycle as CH_CS.
- Requester abandons (CH_CS[gidx] low or CH_ADDR changed during ISSUE/WAIT): the transaction still completes and fills the register. No abort, so the ROM controller is never left mid-burst. CH_OK follows the compare rule.
- Simultaneous requests: exactly one grant per IDLE cycle. RR guarantees each channel is served within NUM_CH transactions.
- BUSY = (state != IDLE).
- ROM_ADDR holds gaddr from IDLE exit until DONE, and holds its last value otherwise.
- NUM_CH = 1: ptr is unused, and behaviour degenerates to a pass-through with a hit register.
- X on CH_ADDR of a non-requesting channel must not affect arbitration. Only pending channels are considered.

Decomposition:
- Shared package raizing_gfx_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - PRIO_RR / PRIO_FIXED constants;
  - default AW/DW.
- One sub-module raizing_rr_pick (NUM_CH, PRIO_MODE): pending vector + ptr -> one-hot grant + index. Purely combinational, tested standalone.
- Hit registers and FSM live in the top.

Test Plan:
- Reset: RESET_N low mid-WAIT on a ch2 transaction -> ROM_CS=0, BUSY=0, all CH_OK=0 immediately. After release, ch2 re-requesting 0x001234 re-issues.
- Single miss then hit: ch0 CS, ADDR=0x000100, ROM_OK after 3 cycles with DOUT=0xDEADBEEF -> CH_OK[0] rises with CH_DOUT[0]=0xDEADBEEF. Same address re-requested -> CH_OK same cycle, no ROM_CS.
- RR fairness (NUM_CH=4, PRIO_MODE=0): all four CS high, distinct addresses, ROM_OK 1 cycle after WAIT entry -> grants in order 0,1,2,3. With ch0 re-requesting new addresses continuously, ch1..3 are each still served within 4 transactions.
- Fixed priority (PRIO_MODE=1): ch1 and ch3 pending together -> ch1 granted first, ch3 next.
- Abandon: ch1 changes ADDR from 0x10 to 0x20 during WAIT -> the fill for 0x10 completes and CH_OK[1] stays 0. Next grant issues ROM_ADDR=0x20.
- MIN_WAIT=2 with stale ROM_OK held high from a previous transaction -> data is not latched until 2 cycles after ROM_CS rises.

Source files
------------

// File: rtl/raizing_gfx_pkg.sv
// Shared definitions for the Raizing graphics ROM fetch arbiter.
package raizing_gfx_pkg;

  // Arbiter transaction state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Arbitration policy selectors.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Default ROM geometry.
  localparam int DEF_AW = 22;
  localparam int DEF_DW = 32;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raizing_rr_pick.sv
// Combinational winner select: round-robin from a pointer, or fixed
// priority with channel 0 highest. Produces a one-hot grant and its index.
module raizing_rr_pick
  import raizing_gfx_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int PRIO_MODE = PRIO_RR,
  localparam int IW        = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  // Scan channels starting at ptr (RR) or at 0 (fixed); first pending wins.
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a signal unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE == PRIO_FIXED) j = k;
      else                         j = int'(ptr_i) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = IW'(j);
      if (!any_o && pend_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/raizing_gfx_rom_arb.sv
// N-channel graphics ROM fetch arbiter with a one-entry hit register per
// channel. Misses are serialised onto a single ROM slot; repeated fetches
// of the same address are answered from the hit register without ROM traffic.
module raizing_gfx_rom_arb
  import raizing_gfx_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MIN_WAIT  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_CH-1:0]    CH_CS,
  input  logic [NUM_CH*AW-1:0] CH_ADDR,
  output logic [NUM_CH-1:0]    CH_OK,
  output logic [NUM_CH*DW-1:0] CH_DOUT,
  output logic                 ROM_CS,
  output logic [AW-1:0]        ROM_ADDR,
  input  logic                 ROM_OK,
  input  logic [DW-1:0]        ROM_DOUT,
  output logic                 BUSY
);

  localparam int         IW        = idx_w(NUM_CH);
  localparam logic [1:0] WAIT_LAST = 2'(MIN_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     gaddr_q, gaddr_d;
  logic              rom_cs_q, rom_cs_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              fill;

  logic [AW-1:0]     tag_q  [NUM_CH];
  logic [DW-1:0]     data_q [NUM_CH];
  logic [NUM_CH-1:0] vld_q;

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [AW-1:0]     sel_addr;

  // Hit compare is combinational so CH_OK drops the cycle the address moves.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign CH_OK[i] = CH_CS[i] & vld_q[i] & (tag_q[i] == CH_ADDR[i*AW +: AW]);
    assign CH_DOUT[i*DW +: DW] = data_q[i];
  end

  assign pend = CH_CS & ~CH_OK;

  raizing_rr_pick #(
    .NUM_CH    (NUM_CH),
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .pend_i (pend),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // One-hot AND-OR address mux: non-granted channels are masked, so an X
  // on an idle channel's address never reaches the grant path.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_addr = sel_addr | ({AW{pick_gnt[i]}} & CH_ADDR[i*AW +: AW]);
    end
  end

  // Next-state and control for the IDLE/ISSUE/WAIT/DONE transaction FSM.
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    gaddr_d  = gaddr_q;
    ptr_d    = ptr_q;
    rom_cs_d = rom_cs_q;
    cnt_d    = cnt_q;
    fill     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gidx_d   = pick_idx;
          gaddr_d  = sel_addr;
          rom_cs_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_ISSUE;
          if (PRIO_MODE == PRIO_RR) begin
            ptr_d = (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + IW'(1);
          end
        end
      end
      ST_ISSUE: begin
        // ROM_OK is not trusted until CS has been held MIN_WAIT cycles.
        if (cnt_q == WAIT_LAST) state_d = ST_WAIT;
        else                    cnt_d   = cnt_q + 2'd1;
      end
      ST_WAIT: begin
        if (ROM_OK) begin
          fill     = 1'b1;
          rom_cs_d = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      gidx_q   <= '0;
      ptr_q    <= '0;
      gaddr_q  <= '0;
      rom_cs_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples the pre-edge values of its neighbours.
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      gaddr_q  <= gaddr_d;
      rom_cs_q <= rom_cs_d;
      cnt_q    <= cnt_d;
    end
  end

  // Hit registers: filled once per completed ROM transaction, abandoned or not.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the per-channel tag/data arrays are reset as well, so CH_DOUT
      // reads 0 after reset instead of leftover contents.
      for (int i = 0; i < NUM_CH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      vld_q <= '0;
    end else if (fill) begin
      tag_q[gidx_q]  <= gaddr_q;
      data_q[gidx_q] <= ROM_DOUT;
      vld_q[gidx_q]  <= 1'b1;
    end
  end

  assign ROM_CS   = rom_cs_q;
  assign ROM_ADDR = gaddr_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_raizing_gfx_rom_arb.sv
// Scoreboard bench for raizing_gfx_rom_arb: expected ROM issue addresses are
// queued by the stimulus and popped by monitors on each ROM_CS rise.
module tb_raizing_gfx_rom_arb;

  localparam int NCH = 4;
  localparam int AW  = 22;
  localparam int DW  = 32;

  logic clk, rst_n;

  // Round-robin, MIN_WAIT=1 instance.
  logic [NCH-1:0]    cs;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    ok;
  logic [NCH*DW-1:0] dout;
  logic              rom_cs, rom_ok, busy;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_dout;

  // Fixed-priority, MIN_WAIT=2 instance.
  logic [NCH-1:0]    cs_fx;
  logic [NCH*AW-1:0] addr_fx;
  logic [NCH-1:0]    ok_fx;
  logic [NCH*DW-1:0] dout_fx;
  logic              rom_cs_fx, rom_ok_fx, busy_fx;
  logic [AW-1:0]     rom_addr_fx;
  logic [DW-1:0]     rom_dout_fx;

  int checks = 0;
  int errors = 0;
  int rom_lat = 2;
  int issues = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_fx_q[$];

  raizing_gfx_rom_arb #(.NUM_CH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(0), .MIN_WAIT(1)) dut (
    .CLK(clk), .RESET_N(rst_n), .CH_CS(cs), .CH_ADDR(addr), .CH_OK(ok), .CH_DOUT(dout),
    .ROM_CS(rom_cs), .ROM_ADDR(rom_addr), .ROM_OK(rom_ok), .ROM_DOUT(rom_dout), .BUSY(busy));

  raizing_gfx_rom_arb #(.NUM_CH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(1), .MIN_WAIT(2)) dut_fx (
    .CLK(clk), .RESET_N(rst_n), .CH_CS(cs_fx), .CH_ADDR(addr_fx), .CH_OK(ok_fx), .CH_DOUT(dout_fx),
    .ROM_CS(rom_cs_fx), .ROM_ADDR(rom_addr_fx), .ROM_OK(rom_ok_fx), .ROM_DOUT(rom_dout_fx),
    .BUSY(busy_fx));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ROM contents seen by the round-robin instance.
  function automatic logic [DW-1:0] rom_data(input logic [AW-1:0] a);
    if (a == 22'h000100) return 32'hDEADBEEF;
    return {10'h2C5, a};
  endfunction

  // ROM contents seen by the fixed-priority instance once data is genuine.
  function automatic logic [DW-1:0] fx_data(input logic [AW-1:0] a);
    return {16'h600D, a[15:0]};
  endfunction

  function automatic logic [DW-1:0] dout_of(input int ch);
    return dout[ch*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] dout_fx_of(input int ch);
    return dout_fx[ch*DW +: DW];
  endfunction

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    addr[ch*AW +: AW] = a;
  endtask

  task automatic set_addr_fx(input int ch, input logic [AW-1:0] a);
    addr_fx[ch*AW +: AW] = a;
  endtask

  // Wait (bounded) until every channel in mask reports CH_OK; cyc = edges taken.
  task automatic wait_ok(input bit use_fx, input logic [NCH-1:0] mask, input string name,
                         output int cyc);
    logic [NCH-1:0] cur;
    cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      cur = use_fx ? ok_fx : ok;
      if ((cur & mask) == mask) begin
        cyc = c;
        return;
      end
    end
    check({name, "_timeout"}, cur & mask, mask);
  endtask

  // Round-robin instance ROM model: OK after rom_lat edges of CS held high.
  initial begin : rom_model
    int cnt;
    cnt = 0;
    rom_ok = 1'b0;
    rom_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (rom_cs) begin
        cnt++;
        rom_ok = (cnt >= rom_lat);
        rom_dout = rom_data(rom_addr);
      end else begin
        cnt = 0;
        rom_ok = 1'b0;
      end
    end
  end

  // Fixed instance ROM model: OK stuck high (stale), data only genuine once
  // CS has been high for three edges, i.e. from the first WAIT cycle.
  initial begin : rom_model_fx
    int cnt;
    cnt = 0;
    rom_ok_fx = 1'b1;
    rom_dout_fx = 32'hBAD0BAD0;
    forever begin
      @(posedge clk); #1;
      if (rom_cs_fx) cnt++;
      else           cnt = 0;
      rom_dout_fx = (cnt >= 3) ? fx_data(rom_addr_fx) : 32'hBAD0BAD0;
    end
  end

  // Monitor: every ROM_CS rise must match the next queued address.
  initial begin : mon_main
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_cs && !prev) begin
        issues++;
        if (exp_q.size() == 0) check("rom_issue_unexpected", exp_q.size(), 1);
        else begin
          check("rom_addr", rom_addr, exp_q.pop_front());
          check("busy_on_issue", busy, 1'b1);
        end
      end
      prev = rom_cs;
    end
  end

  initial begin : mon_fx
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_cs_fx && !prev) begin
        if (exp_fx_q.size() == 0) check("fx_rom_issue_unexpected", exp_fx_q.size(), 1);
        else check("fx_rom_addr", rom_addr_fx, exp_fx_q.pop_front());
      end
      prev = rom_cs_fx;
    end
  end

  initial begin : stim
    int cyc;
    int start;
    bit done;
    rst_n = 1'b0;
    cs = '0; addr = '0;
    cs_fx = '0; addr_fx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_rom_cs", rom_cs, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rom_addr", rom_addr, 22'h0);
    check("rst_ch_ok", ok, 4'h0);
    check("rst_ch_dout", dout, '0);

    // Fixed priority, MIN_WAIT=2, stale ROM_OK held high.
    exp_fx_q.push_back(22'h000055);
    @(negedge clk); set_addr_fx(2, 22'h000055); cs_fx = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("fx_stale_ok_cyc%0d", c), ok_fx[2], (c == 4));
    end
    check("fx_stale_data", dout_fx_of(2), 32'h600D0055);
    @(negedge clk); cs_fx = '0;
    repeat (2) @(negedge clk);
    // ch1 and ch3 together: fixed priority serves ch1 first even though a
    // round-robin pointer would now point at ch3.
    exp_fx_q.push_back(22'h000071);
    exp_fx_q.push_back(22'h000073);
    set_addr_fx(1, 22'h000071); set_addr_fx(3, 22'h000073); cs_fx = 4'b1010;
    wait_ok(1'b1, 4'b1010, "fx_prio", cyc);
    check("fx_prio_d1", dout_fx_of(1), 32'h600D0071);
    check("fx_prio_d3", dout_fx_of(3), 32'h600D0073);
    @(negedge clk); cs_fx = '0;

    // Round-robin: all four request at once from pointer 0.
    rom_lat = 2;
    for (int i = 0; i < NCH; i++) exp_q.push_back(22'h001000 + 22'(i));
    @(negedge clk);
    for (int i = 0; i < NCH; i++) set_addr(i, 22'h001000 + 22'(i));
    cs = 4'hF;
    wait_ok(1'b0, 4'hF, "rr_all", cyc);
    check("rr_d0", dout_of(0), 32'hB1401000);
    check("rr_d1", dout_of(1), 32'hB1401001);
    check("rr_d2", dout_of(2), 32'hB1401002);
    check("rr_d3", dout_of(3), 32'hB1401003);
    @(negedge clk); cs = '0;
    repeat (3) @(negedge clk);

    // Single miss (ROM OK 3 edges after CS) then hit on the same address.
    rom_lat = 3;
    exp_q.push_back(22'h000100);
    set_addr(0, 22'h000100); cs = 4'b0001;
    wait_ok(1'b0, 4'b0001, "miss", cyc);
    check("miss_latency", cyc, 4);
    check("miss_data", dout_of(0), 32'hDEADBEEF);
    @(negedge clk); cs = '0;
    repeat (2) @(negedge clk);
    cs = 4'b0001;
    #1;
    check("hit_same_cycle", ok[0], 1'b1);
    check("hit_data", dout_of(0), 32'hDEADBEEF);
    repeat (4) @(posedge clk);
    #1;
    check("hit_no_rom_cs", rom_cs, 1'b0);
    check("hit_not_busy", busy, 1'b0);
    @(negedge clk); cs = '0;
    repeat (2) @(negedge clk);

    // Abandon: ch1 moves 0x10 -> 0x20 while WAIT; fill for 0x10 still lands.
    rom_lat = 4;
    exp_q.push_back(22'h000010);
    exp_q.push_back(22'h000020);
    set_addr(1, 22'h000010); cs = 4'b0010;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin @(posedge clk); #1; done = rom_cs; end
    check("abandon_issue_seen", rom_cs, 1'b1);
    @(posedge clk); #1;
    set_addr(1, 22'h000020);
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin @(posedge clk); #1; done = !rom_cs; end
    check("abandon_rom_cs_low", rom_cs, 1'b0);
    check("abandon_ok_low", ok[1], 1'b0);
    check("abandon_fill", dout_of(1), 32'hB1400010);
    wait_ok(1'b0, 4'b0010, "abandon_reissue", cyc);
    check("abandon_new_data", dout_of(1), 32'hB1400020);
    @(negedge clk); cs = '0;
    repeat (2) @(negedge clk);

    // Fairness: pointer is at 2; ch0 keeps moving its address after each hit.
    rom_lat = 2;
    exp_q.push_back(22'h000302);
    exp_q.push_back(22'h000303);
    exp_q.push_back(22'h000400);
    exp_q.push_back(22'h000301);
    start = issues;
    set_addr(1, 22'h000301); set_addr(2, 22'h000302); set_addr(3, 22'h000303);
    set_addr(0, 22'h000400);
    cs = 4'hF;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (ok[3:1] == 3'b111) begin
        cs = '0;
        done = 1'b1;
      end else if (ok[0]) begin
        set_addr(0, addr[AW-1:0] + 22'd1);
      end
    end
    check("fair_served", done, 1'b1);
    repeat (3) @(negedge clk);
    check("fair_txn_count", issues - start, 4);

    // Async reset while ch2 waits on a slow ROM, then re-issue after release.
    rom_lat = 50;
    exp_q.push_back(22'h001234);
    set_addr(2, 22'h001234); cs = 4'b0100;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin @(posedge clk); #1; done = rom_cs; end
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rom_cs", rom_cs, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ch_ok", ok, 4'h0);
    check("mid_rst_dout", dout, '0);
    rom_lat = 2;
    exp_q.push_back(22'h001234);
    @(negedge clk); rst_n = 1'b1;
    wait_ok(1'b0, 4'b0100, "post_rst", cyc);
    check("post_rst_data", dout_of(2), 32'hB1401234);
    @(negedge clk); cs = '0;
    repeat (4) @(negedge clk);

    check("sb_main_drained", exp_q.size(), 0);
    check("sb_fx_drained", exp_fx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
